md_sequencer: RTL and testbench

- Control FSM for the execute-stage multiply/divide resource.
- Issues start commands to an iterative multiply/divide datapath and counts its latency.
- Generates HI/LO write enables and source selects for that datapath.
- Produces the stall request that the hazard unit uses to hold a D-stage multiply/divide-class instruction while the unit is busy.
- Contains no arithmetic and no HI/LO storage; it only sequences.

---
 rtl/md_sequencer_pkg.sv | 40 ++++
 rtl/md_latency_counter.sv | 26 ++
 rtl/md_sequencer.sv | 119 +++++++++++
 tb/tb_md_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared opcode, md_op and state encodings for the execute-stage multiply/divide sequencer.
// Also used by the E-stage controller that drives e_op.
package md_sequencer_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam logic [1:0] MDOP_MULT  = 2'b00;
   localparam logic [1:0] MDOP_MULTU = 2'b01;
   localparam logic [1:0] MDOP_DIV   = 2'b10;
   localparam logic [1:0] MDOP_DIVU  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // Opcodes that occupy the iterative datapath.
   function automatic logic is_arith(input logic [3:0] op);
      return (op >= MD_MULT) && (op <= MD_DIVU);
   endfunction

   function automatic logic is_md(input logic [3:0] op);
      return (op >= MD_MULT) && (op <= MD_MFLO);
   endfunction

   function automatic logic [1:0] md_op_enc(input logic [3:0] op);
      logic [3:0] t;
      t = op - 4'd1;
      return t[1:0];
   endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter for fixed-latency sequencing; expire marks the last counted cycle.
module md_latency_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage multiply/divide sequencer: issue, latency count, HI/LO write enables, stall.
// Build option: MD_DONE_HANDSHAKE_EN ends BUSY on md_done instead of the latency counter.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       e_valid,
   input  logic [3:0] e_op,
   input  logic       e_divisor_zero,
   input  logic       d_is_md,
   output logic       md_start,
   output logic [1:0] md_op,
   input  logic       md_done,
   output logic       hi_we,
   output logic       lo_we,
   output logic       hilo_src,
   output logic       busy,
   output logic       stall_md,
   output logic       illegal
);

   md_state_e        state, state_nxt;
   logic             div0_q;
   logic [1:0]       op_q;
   logic             e_arith, e_md, e_is_div, issue, finish, cnt_expire;
   logic [CNT_W-1:0] load_val;

   assign e_arith  = e_valid && is_arith(e_op);
   assign e_md     = e_valid && is_md(e_op);
   assign e_is_div = (e_op == MD_DIV) || (e_op == MD_DIVU);
   assign issue    = (state == ST_IDLE) && e_arith;
   assign load_val = e_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   md_latency_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (issue),
      .load_val (load_val),
      .dec      (state == ST_BUSY),
      .expire   (cnt_expire)
   );

`ifdef MD_DONE_HANDSHAKE_EN
   logic cnt_expire_unused;
   assign cnt_expire_unused = cnt_expire;
   assign finish = (state == ST_BUSY) && md_done;
`else
   logic md_done_unused;
   assign md_done_unused = md_done;
   assign finish = (state == ST_BUSY) && cnt_expire;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Divide-by-zero is captured at issue so the final cycle can suppress the write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div0_q <= 1'b0;
         op_q   <= MDOP_MULT;
      end else if (issue) begin
         div0_q <= e_is_div && e_divisor_zero;
         op_q   <= md_op_enc(e_op);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (issue)  state_nxt = ST_BUSY;
         ST_BUSY: if (finish) state_nxt = ST_IDLE;
         default:             state_nxt = ST_IDLE;
      endcase
   end

   // All outputs are held low while reset is asserted, even though E inputs may be live.
   always_comb begin
      md_start = 1'b0;
      md_op    = MDOP_MULT;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      hilo_src = 1'b0;
      busy     = 1'b0;
      stall_md = 1'b0;
      illegal  = 1'b0;
      if (!reset) begin
         md_op = op_q;
         unique case (state)
            ST_IDLE: begin
               if (issue) begin
                  md_start = 1'b1;
                  md_op    = md_op_enc(e_op);
               end
               hi_we    = e_valid && (e_op == MD_MTHI);
               lo_we    = e_valid && (e_op == MD_MTLO);
               hilo_src = e_valid && ((e_op == MD_MTHI) || (e_op == MD_MTLO));
            end
            ST_BUSY: begin
               busy    = 1'b1;
               hi_we   = finish && !div0_q;
               lo_we   = finish && !div0_q;
               illegal = e_md;
            end
            default: ;
         endcase
         stall_md = d_is_md && (busy || e_arith);
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer; expected output vectors are queued per stimulus cycle.
`timescale 1ns/1ps
module tb_md_sequencer;
   import md_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       e_valid = 1'b0;
   logic [3:0] e_op = MD_NONE;
   logic       e_divisor_zero = 1'b0;
   logic       d_is_md = 1'b0;
   logic       md_done = 1'b0;
   logic       md_start, hi_we, lo_we, hilo_src, busy, stall_md, illegal;
   logic [1:0] md_op;

   int checks = 0;
   int errors = 0;
   logic [8:0] obs, exp_v, msk;
   logic [8:0] sb[$];

   md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op),
      .e_divisor_zero(e_divisor_zero), .d_is_md(d_is_md),
      .md_start(md_start), .md_op(md_op), .md_done(md_done),
      .hi_we(hi_we), .lo_we(lo_we), .hilo_src(hilo_src), .busy(busy),
      .stall_md(stall_md), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Vector: {start, md_op[1:0], hi_we, lo_we, hilo_src, busy, stall_md, illegal}
   function automatic logic [8:0] ev(input logic st, input logic [1:0] op, input logic hi,
                                     input logic lo, input logic src, input logic bz,
                                     input logic stl, input logic ill);
      return {st, op, hi, lo, src, bz, stl, ill};
   endfunction

   task automatic step(input logic r, input logic v, input logic [3:0] op, input logic dz,
                       input logic dmd, input logic dn);
      @(negedge clk);
      reset = r; e_valid = v; e_op = op; e_divisor_zero = dz; d_is_md = dmd; md_done = dn;
      #2;
      obs = {md_start, md_op, hi_we, lo_we, hilo_src, busy, stall_md, illegal};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         sb.push_back(9'd0);
         step(1'b1, 1'b1, MD_MULT, 1'b0, 1'b1, 1'b1);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_mult();
      for (int i = 0; i < 7; i++) begin
         if (i == 0) sb.push_back(ev(1, MDOP_MULT, 0, 0, 0, 0, 0, 0));
         else if (i <= 5) sb.push_back(ev(0, 0, i == 5, i == 5, 0, 1, 0, 0));
         else sb.push_back(9'd0);
         step(1'b0, i == 0, (i == 0) ? MD_MULT : MD_NONE, 1'b0, 1'b0, 1'b0);
         exp_v = sb.pop_front();
         msk = exp_v[8] ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL mult cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_divu_zero();
      for (int i = 0; i < 12; i++) begin
         if (i == 0) sb.push_back(ev(1, MDOP_DIVU, 0, 0, 0, 0, 0, 0));
         else if (i <= 10) sb.push_back(ev(0, 0, 0, 0, 0, 1, 0, 0));
         else sb.push_back(9'd0);
         step(1'b0, i == 0, (i == 0) ? MD_DIVU : MD_NONE, 1'b1, 1'b0, 1'b0);
         exp_v = sb.pop_front();
         msk = exp_v[8] ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL divu_zero cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_div_stall();
      logic [3:0] op;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) sb.push_back(ev(1, MDOP_DIV, 0, 0, 0, 0, 1, 0));
         else if (i <= 10) sb.push_back(ev(0, 0, i == 10, i == 10, 0, 1, 1, 0));
         else sb.push_back(9'd0);
         op = (i == 0) ? MD_DIV : ((i == 11) ? MD_MFLO : MD_NONE);
         step(1'b0, (i == 0) || (i == 11), op, 1'b0, 1'b1, 1'b0);
         exp_v = sb.pop_front();
         msk = exp_v[8] ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL div_stall cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_mthi();
      logic [3:0] ops[9] = '{MD_MTHI, MD_MTLO, MD_MFHI, MD_MULT, MD_MTHI,
                             MD_NONE, MD_NONE, MD_NONE, MD_NONE};
      for (int i = 0; i < 9; i++) begin
         case (i)
            0: sb.push_back(ev(0, 0, 1, 0, 1, 0, 0, 0));
            1: sb.push_back(ev(0, 0, 0, 1, 1, 0, 0, 0));
            2: sb.push_back(9'd0);
            3: sb.push_back(ev(1, MDOP_MULT, 0, 0, 0, 0, 0, 0));
            4: sb.push_back(ev(0, 0, 0, 0, 0, 1, 0, 1));
            default: sb.push_back(ev(0, 0, i == 8, i == 8, 0, 1, 0, 0));
         endcase
         step(1'b0, i <= 4, ops[i], 1'b0, 1'b0, 1'b0);
         exp_v = sb.pop_front();
         msk = exp_v[8] ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL mthi cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] op;
      for (int i = 0; i < 18; i++) begin
         if (i == 0) sb.push_back(ev(1, MDOP_MULTU, 0, 0, 0, 0, 0, 0));
         else if (i <= 5) sb.push_back(ev(0, 0, i == 5, i == 5, 0, 1, 0, 0));
         else if (i == 6) sb.push_back(ev(1, MDOP_DIVU, 0, 0, 0, 0, 0, 0));
         else if (i <= 16) sb.push_back(ev(0, 0, i == 16, i == 16, 0, 1, 0, 0));
         else sb.push_back(9'd0);
         op = (i == 0) ? MD_MULTU : ((i == 6) ? MD_DIVU : MD_NONE);
         step(1'b0, (i == 0) || (i == 6), op, 1'b0, 1'b0, 1'b0);
         exp_v = sb.pop_front();
         msk = exp_v[8] ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] op;
      for (int i = 0; i < 18; i++) begin
         if (i == 0) sb.push_back(ev(1, MDOP_MULT, 0, 0, 0, 0, 0, 0));
         else if (i <= 2) sb.push_back(ev(0, 0, 0, 0, 0, 1, 0, 0));
         else if (i <= 10) sb.push_back(9'd0);
         else if (i == 11) sb.push_back(ev(1, MDOP_MULTU, 0, 0, 0, 0, 0, 0));
         else if (i <= 16) sb.push_back(ev(0, 0, i == 16, i == 16, 0, 1, 0, 0));
         else sb.push_back(9'd0);
         op = ((i == 0) || (i == 4)) ? MD_MULT : ((i == 11) ? MD_MULTU : MD_NONE);
         step((i == 3) || (i == 4), (i == 0) || (i == 4) || (i == 11), op, 1'b0, 1'b0, 1'b0);
         exp_v = sb.pop_front();
         msk = (exp_v[8] || i == 3 || i == 4) ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL reset_mid cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

`ifdef MD_DONE_HANDSHAKE_EN
   task automatic test_handshake();
      logic [3:0] op;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) sb.push_back(ev(1, MDOP_DIV, 0, 0, 0, 0, 0, 0));
         else if (i <= 7) sb.push_back(ev(0, 0, i == 7, i == 7, 0, 1, 0, 0));
         else if (i == 8) sb.push_back(9'd0);
         else sb.push_back(ev(0, 0, 0, 1, 1, 0, 0, 0));
         op = (i == 0) ? MD_DIV : ((i == 9) ? MD_MTLO : MD_NONE);
         step(1'b0, (i == 0) || (i == 9), op, 1'b0, 1'b0, i >= 7);
         exp_v = sb.pop_front();
         msk = exp_v[8] ? 9'h1FF : 9'h13F;
         checks++;
         if ((obs & msk) !== exp_v) begin
            errors++;
            $display("FAIL handshake cyc %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef MD_DONE_HANDSHAKE_EN
      test_handshake();
`else
      test_mult();
      test_divu_zero();
      test_div_stall();
      test_mthi();
      test_back_to_back();
      test_reset_mid();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
